addition_subtraction: RTL and testbench



---
 rtl/addition_subtraction.sv | 134 +++++++++++++
 tb/tb_addition_subtraction.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/addition_subtraction.sv
// addition_subtraction: fp32 add/sub with truncation and denormal flush.
// Define FP_ADD_SUB_PIPE_EN for an extra register after alignment.
module addition_subtraction (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        out_valid,
  output logic        Exception,
  output logic [31:0] result
);

  typedef struct packed {
    logic        exc;
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [23:0] sig_l;
    logic [23:0] sig_s;
  } align_t;

  function automatic logic [4:0] lzc(input logic [23:0] v);
    lzc = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc = 5'(23 - i);
  endfunction

  align_t      al_d;
  align_t      al;
  logic        v2;

  logic        sa;
  logic        sb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [23:0] ms;
  logic [7:0]  ed;
  logic        swap;

  always_comb begin
    sa   = a_operand[31];
    sb   = b_operand[31] ^ AddBar_Sub;
    ea   = a_operand[30:23];
    eb   = b_operand[30:23];
    ma   = (ea == 8'd0) ? 24'd0 : {1'b1, a_operand[22:0]};
    mb   = (eb == 8'd0) ? 24'd0 : {1'b1, b_operand[22:0]};
    swap = (eb > ea) || ((eb == ea) && (mb > ma));
    ms   = swap ? ma : mb;
    ed   = swap ? (eb - ea) : (ea - eb);
    al_d         = '0;
    al_d.exc     = (&ea) | (&eb);
    al_d.sign    = swap ? sb : sa;
    al_d.eff_sub = sa ^ sb;
    al_d.exp     = swap ? eb : ea;
    al_d.sig_l   = swap ? mb : ma;
    al_d.sig_s   = (ed >= 8'd24) ? 24'd0 : (ms >> ed);
  end

`ifdef FP_ADD_SUB_PIPE_EN
  align_t al_q;
  logic   v_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= 1'b0;
      al_q <= '0;
    end else begin
      v_q <= in_valid;
      if (in_valid) al_q <= al_d;
    end
  end

  assign al = al_q;
  assign v2 = v_q;
`else
  assign al = al_d;
  assign v2 = in_valid;
`endif

  logic [24:0]       sum;
  logic [23:0]       dif;
  logic [23:0]       nsig;
  logic [4:0]        lz;
  logic signed [9:0] nexp;
  logic [31:0]       res_d;

  always_comb begin
    sum  = {1'b0, al.sig_l} + {1'b0, al.sig_s};
    dif  = al.sig_l - al.sig_s;
    lz   = lzc(dif);
    nsig = '0;
    nexp = '0;
    if (al.eff_sub) begin
      nsig = dif << lz;
      nexp = $signed({2'b00, al.exp}) - $signed({5'd0, lz});
    end else if (sum[24]) begin
      nsig = sum[24:1];
      nexp = $signed({2'b00, al.exp}) + 10'sd1;
    end else begin
      nsig = sum[23:0];
      nexp = $signed({2'b00, al.exp});
    end
    // a zero significand here means both inputs were zero
    if (al.exc)
      res_d = 32'h7FC00000;
    else if (al.eff_sub && (dif == 24'd0))
      res_d = 32'h0000_0000;
    else if (nexp >= 10'sd255)
      res_d = {al.sign, 8'hFF, 23'd0};
    else if ((nexp <= 10'sd0) || !nsig[23])
      res_d = {al.sign, 31'd0};
    else
      res_d = {al.sign, nexp[7:0], nsig[22:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      Exception <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        result    <= res_d;
        Exception <= al.exc;
      end
    end
  end

endmodule

// File: tb/tb_addition_subtraction.sv
// tb_addition_subtraction: scoreboard bench for the fp32 adder/subtractor.
// Random and directed operands checked against an integer reference model.
module tb_addition_subtraction;

`ifdef FP_ADD_SUB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        AddBar_Sub;
  logic        out_valid;
  logic        Exception;
  logic [31:0] result;

  typedef struct {
    int          due;
    logic        exc;
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] hold_res = 32'd0;
  logic        hold_exc = 1'b0;
  bit          started = 1'b0;

  addition_subtraction dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .AddBar_Sub(AddBar_Sub),
    .out_valid (out_valid),
    .Exception (Exception),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference: integer significands, normalised by plain loops.
  function automatic logic [32:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic sub);
    logic        sa, sb, s;
    int          ea, eb, e, es, d;
    longint      ma, mb, ml, msm, r;
    logic [31:0] res;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return {1'b1, 32'h7FC00000};
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'd0 : longint'(a[22:0]) + 64'd8388608;
    mb = (eb == 0) ? 64'd0 : longint'(b[22:0]) + 64'd8388608;
    if (eb > ea || (eb == ea && mb > ma)) begin
      s = sb; e = eb; ml = mb; es = ea; msm = ma;
    end else begin
      s = sa; e = ea; ml = ma; es = eb; msm = mb;
    end
    d = e - es;
    msm = (d >= 24) ? 64'd0 : (msm >> d);
    r = (sa == sb) ? ml + msm : ml - msm;
    if (r == 0) begin
      res = (sa == sb) ? {s, 31'd0} : 32'd0;
    end else begin
      while (r >= 64'd16777216) begin r = r >> 1; e = e + 1; end
      while (r < 64'd8388608) begin r = r << 1; e = e - 1; end
      if (e >= 255)     res = {s, 8'hFF, 23'd0};
      else if (e <= 0)  res = {s, 31'd0};
      else              res = {s, e[7:0], r[22:0]};
    end
    return {1'b0, res};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic opx(input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic [31:0] res,
                     input logic exc);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1;
    a_operand = a; b_operand = b; AddBar_Sub = sub;
    e.due = cyc + LAT; e.exc = exc; e.res = res;
    e.a = a; e.b = b; e.sub = sub;
    q.push_back(e);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic sub);
    logic [32:0] m;
    m = model(a, b, sub);
    opx(a, b, sub, m[31:0], m[32]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      a_operand = $urandom; b_operand = $urandom; AddBar_Sub = 1'($urandom);
    end
  endtask

  task automatic do_reset(input logic with_valid);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = with_valid;
    a_operand = $urandom; b_operand = $urandom;
    while (q.size() > 0 && q[$].due > cyc) q.delete(q.size() - 1);
    @(posedge clk); #1;
    hold_res = 32'd0; hold_exc = 1'b0; started = 1'b1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_exception", {31'd0, Exception}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'hFE;
      3: v[30:23] = 8'h01;
      default: ;
    endcase
    return v;
  endfunction

  task automatic rnd_ops(input int n, input bit gaps);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = rnd_op();
      case ($urandom_range(0, 3))
        0: b = rnd_op();
        1: b = {1'($urandom), a[30:23], 23'($urandom)};
        2: b = a ^ {1'($urandom), 31'd0};
        default: b = {1'($urandom), a[30:23] + 8'($urandom_range(0, 30)),
                      23'($urandom)};
      endcase
      op(a, b, 1'($urandom));
      if (gaps && $urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (out_valid === 1'b1) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (cyc %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("latency", 32'(cyc), 32'(e.due));
            chk($sformatf("result %h %s %h", e.a, e.sub ? "-" : "+", e.b),
                result, e.res);
            chk("exception", {31'd0, Exception}, {31'd0, e.exc});
            hold_res = e.res; hold_exc = e.exc;
          end
        end else begin
          chk("out_valid_known", {31'd0, out_valid}, 32'd0);
          chk("hold_result", result, hold_res);
          chk("hold_exception", {31'd0, Exception}, {31'd0, hold_exc});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    a_operand = '0; b_operand = '0; AddBar_Sub = 1'b0;
    do_reset(1'b0);

    opx(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
    idle(2);
    opx(32'h415ED852, 32'h40DED852, 1'b0, 32'h41A7223D, 1'b0);
    opx(32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000, 1'b0);
    opx(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0);
    opx(32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1);
    idle(1);
    opx(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0);
    opx(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0);
    opx(32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0);
    opx(32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 1'b0);
    opx(32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 1'b0);
    opx(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0);
    idle(3);

    rnd_ops(400, 1'b1);
    rnd_ops(25, 1'b0);
    do_reset(1'b1);
    rnd_ops(25, 1'b0);
    do_reset(1'b1);
    rnd_ops(400, 1'b1);
    idle(LAT + 3);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
